// File: rtl/mult_div_pkg.sv
// Shared types for the MULT/DIV sequencer: FSM states, exception causes and unit select codes.
package mult_div_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        EXC   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        DIVZ = 2'd1,
        TMO  = 2'd2
    } cause_t;

    localparam logic SEL_MULT = 1'b0;
    localparam logic SEL_DIV  = 1'b1;

endpackage

// File: rtl/mult_div_sequencer_if.sv
// Request, unit handshake and commit signals between control_unit, the sequencer and the mult/div units.
interface mult_div_sequencer_if #(
    parameter int CNT_W = 6
);
    logic             op_valid;
    logic             op_is_div;
    logic             div_zero;
    logic             mult_done;
    logic             div_done;
    logic             op_ready;
    logic             busy;
    logic             mult_start;
    logic             div_start;
    logic             mux_high;
    logic             mux_low;
    logic             hi_write;
    logic             lo_write;
    logic             done;
    logic             div_zero_exc;
    logic             timeout_err;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output op_valid, op_is_div, div_zero, mult_done, div_done,
        input  op_ready, busy, mult_start, div_start, mux_high, mux_low,
               hi_write, lo_write, done, div_zero_exc, timeout_err, cycle_count
    );

    modport slave (
        input  op_valid, op_is_div, div_zero, mult_done, div_done,
        output op_ready, busy, mult_start, div_start, mux_high, mux_low,
               hi_write, lo_write, done, div_zero_exc, timeout_err, cycle_count
    );

endinterface

// File: rtl/mult_div_sequencer_wait_counter.sv
// Up-counting wait timer with clear/enable and a terminal-count flag at TIMEOUT-1.
module wait_counter #(
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6
) (
    input  logic             clk,
    input  logic             reset_in,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (!reset_in) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign tc = (count == TC_VAL);

endmodule

// File: rtl/mult_div_sequencer.sv
// Sequences one MULT/DIV at a time: start pulse, wait for the selected unit, commit HI/LO or raise an exception.
//   state | meaning
//   IDLE  | ready for a request
//   START | one-cycle start pulse to the selected unit
//   WAIT  | waiting for the selected unit's done, bounded by TIMEOUT
//   WRITE | one-cycle HI/LO commit and done pulse
//   EXC   | one-cycle divide-by-zero or timeout pulse
module mult_div_sequencer
    import mult_div_pkg::*;
#(
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6
) (
    input  logic                 clk,
    input  logic                 reset_in,
    mult_div_sequencer_if.slave  bus
);

    state_t           state_q, state_d;
    cause_t           cause_q, cause_d;
    logic             op_sel_q, op_sel_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
    logic [CNT_W-1:0] cnt;
    logic             cnt_tc, cnt_clear, cnt_en;
    logic             sel_done;

    logic o_op_ready, o_busy, o_mult_start, o_div_start;
    logic o_hi_write, o_lo_write, o_done, o_div_zero_exc, o_timeout_err;

    wait_counter #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wait_counter (
        .clk      (clk),
        .reset_in (reset_in),
        .clear    (cnt_clear),
        .enable   (cnt_en),
        .count    (cnt),
        .tc       (cnt_tc)
    );

    assign sel_done = (op_sel_q == SEL_DIV) ? bus.div_done : bus.mult_done;

    always_ff @(posedge clk) begin
        if (!reset_in) begin
            state_q       <= IDLE;
            cause_q       <= NONE;
            op_sel_q      <= SEL_MULT;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cause_q       <= cause_d;
            op_sel_q      <= op_sel_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cause_d        = cause_q;
        op_sel_d       = op_sel_q;
        cycle_count_d  = cycle_count_q;
        cnt_clear      = 1'b0;
        cnt_en         = 1'b0;
        o_op_ready     = 1'b0;
        o_busy         = 1'b0;
        o_mult_start   = 1'b0;
        o_div_start    = 1'b0;
        o_hi_write     = 1'b0;
        o_lo_write     = 1'b0;
        o_done         = 1'b0;
        o_div_zero_exc = 1'b0;
        o_timeout_err  = 1'b0;

        case (state_q)
            IDLE: begin
                o_op_ready = 1'b1;
                if (bus.op_valid) begin
                    // A zero divisor never reaches the divider.
                    if (bus.op_is_div && bus.div_zero) begin
                        cause_d = DIVZ;
                        state_d = EXC;
                    end else begin
                        op_sel_d = bus.op_is_div;
                        state_d  = START;
                    end
                end
            end
            START: begin
                o_busy       = 1'b1;
                o_mult_start = (op_sel_q == SEL_MULT);
                o_div_start  = (op_sel_q == SEL_DIV);
                cnt_clear    = 1'b1;
                state_d      = WAIT;
            end
            WAIT: begin
                o_busy = 1'b1;
                // Done is checked first so a result arriving on the last allowed cycle is kept.
                if (sel_done) begin
                    cycle_count_d = cnt + CNT_W'(1);
                    state_d       = WRITE;
                end else if (cnt_tc) begin
                    cause_d = TMO;
                    state_d = EXC;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            WRITE: begin
                o_busy     = 1'b1;
                o_hi_write = 1'b1;
                o_lo_write = 1'b1;
                o_done     = 1'b1;
                state_d    = IDLE;
            end
            EXC: begin
                o_busy         = 1'b1;
                o_div_zero_exc = (cause_q == DIVZ);
                o_timeout_err  = (cause_q == TMO);
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.op_ready     = o_op_ready;
    assign bus.busy         = o_busy;
    assign bus.mult_start   = o_mult_start;
    assign bus.div_start    = o_div_start;
    assign bus.mux_high     = op_sel_q;
    assign bus.mux_low      = op_sel_q;
    assign bus.hi_write     = o_hi_write;
    assign bus.lo_write     = o_lo_write;
    assign bus.done         = o_done;
    assign bus.div_zero_exc = o_div_zero_exc;
    assign bus.timeout_err  = o_timeout_err;
    assign bus.cycle_count  = cycle_count_q;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Directed bench for mult_div_sequencer: a vector table of single operations plus back-to-back and mid-WAIT reset sequences.
module tb_mult_div_sequencer;

    localparam int CNT_W  = 6;
    localparam int WINDOW = 46;

    logic clk;
    logic reset_in;
    int   checks;
    int   errors;

    mult_div_sequencer_if #(.CNT_W(CNT_W)) bus_if ();

    mult_div_sequencer #(
        .TIMEOUT (40),
        .CNT_W   (CNT_W)
    ) dut (
        .clk      (clk),
        .reset_in (reset_in),
        .bus      (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Times are cycle offsets after the accepting edge; -1 means the event never occurs.
    typedef struct {
        logic is_div;
        logic dz;
        int   done_k;
        logic wrong_done;
        int   exp_mstart_at;
        int   exp_dstart_at;
        int   exp_write_at;
        int   exp_dz_at;
        int   exp_tmo_at;
        int   exp_idle_at;
        int   exp_cc;
        logic exp_mux;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus_if.op_valid  = 1'b0;
        bus_if.op_is_div = 1'b0;
        bus_if.div_zero  = 1'b0;
        bus_if.mult_done = 1'b0;
        bus_if.div_done  = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int m_at, d_at, w_at, l_at, dn_at, dz_at, tmo_at, idle_at;
        int n_m, n_d, n_w, n_dn;
        logic mh, ml;
        string tag;
        m_at = -1; d_at = -1; w_at = -1; l_at = -1; dn_at = -1;
        dz_at = -1; tmo_at = -1; idle_at = -1;
        n_m = 0; n_d = 0; n_w = 0; n_dn = 0;
        mh = 1'b0; ml = 1'b0;
        tag = $sformatf("v%0d", idx);

        chk({tag, "_ready_before"}, int'(bus_if.op_ready), 1);
        bus_if.op_valid  = 1'b1;
        bus_if.op_is_div = v.is_div;
        bus_if.div_zero  = v.dz;
        bus_if.mult_done = v.wrong_done && v.is_div;
        bus_if.div_done  = v.wrong_done && !v.is_div;

        for (int c = 1; c <= WINDOW; c++) begin
            step();
            if (c == 1) begin
                mh = bus_if.mux_high;
                ml = bus_if.mux_low;
                chk({tag, "_busy_c1"}, int'(bus_if.busy), 1);
            end
            if (bus_if.mult_start) begin n_m++; if (m_at < 0) m_at = c; end
            if (bus_if.div_start)  begin n_d++; if (d_at < 0) d_at = c; end
            if (bus_if.hi_write)   begin n_w++; if (w_at < 0) w_at = c; end
            if (bus_if.lo_write && l_at < 0) l_at = c;
            if (bus_if.done)       begin n_dn++; if (dn_at < 0) dn_at = c; end
            if (bus_if.div_zero_exc && dz_at < 0) dz_at = c;
            if (bus_if.timeout_err && tmo_at < 0) tmo_at = c;
            if (bus_if.op_ready && idle_at < 0) idle_at = c;
            bus_if.op_valid = 1'b0;
            if (v.done_k > 0) begin
                if (v.is_div) bus_if.div_done  = (c == v.done_k + 1);
                else          bus_if.mult_done = (c == v.done_k + 1);
            end
        end
        clear_inputs();

        chk({tag, "_mstart_at"}, m_at, v.exp_mstart_at);
        chk({tag, "_dstart_at"}, d_at, v.exp_dstart_at);
        chk({tag, "_mstart_n"}, n_m, (v.exp_mstart_at >= 0) ? 1 : 0);
        chk({tag, "_dstart_n"}, n_d, (v.exp_dstart_at >= 0) ? 1 : 0);
        chk({tag, "_hi_write_at"}, w_at, v.exp_write_at);
        chk({tag, "_lo_write_at"}, l_at, v.exp_write_at);
        chk({tag, "_hi_write_n"}, n_w, (v.exp_write_at >= 0) ? 1 : 0);
        chk({tag, "_done_at"}, dn_at, v.exp_write_at);
        chk({tag, "_done_n"}, n_dn, (v.exp_write_at >= 0) ? 1 : 0);
        chk({tag, "_dz_exc_at"}, dz_at, v.exp_dz_at);
        chk({tag, "_tmo_at"}, tmo_at, v.exp_tmo_at);
        chk({tag, "_ready_at"}, idle_at, v.exp_idle_at);
        chk({tag, "_cycle_count"}, int'(bus_if.cycle_count), v.exp_cc);
        chk({tag, "_mux_high"}, int'(mh), int'(v.exp_mux));
        chk({tag, "_mux_low"}, int'(ml), int'(v.exp_mux));
    endtask

    initial begin
        int n_done, n_mstart, n_ready;
        checks = 0;
        errors = 0;

        //            div   dz    k   wrong  mst dst  wr  dz  tmo idle cc  mux
        vecs[0] = '{1'b0, 1'b0,  3, 1'b0,   1, -1,  5, -1,  -1,  6,  3, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 32, 1'b0,  -1,  1, 34, -1,  -1, 35, 32, 1'b1};
        vecs[2] = '{1'b1, 1'b1,  0, 1'b0,  -1, -1, -1,  1,  -1,  2, 32, 1'b1};
        vecs[3] = '{1'b0, 1'b0,  0, 1'b1,   1, -1, -1, -1,  42, 43, 32, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 40, 1'b0,   1, -1, 42, -1,  -1, 43, 40, 1'b0};
        vecs[5] = '{1'b0, 1'b0,  2, 1'b1,   1, -1,  4, -1,  -1,  5,  2, 1'b0};
        vecs[6] = '{1'b0, 1'b0,  1, 1'b0,   1, -1,  3, -1,  -1,  4,  1, 1'b0};
        vecs[7] = '{1'b1, 1'b0,  5, 1'b1,  -1,  1,  7, -1,  -1,  8,  5, 1'b1};

        clear_inputs();
        reset_in = 1'b0;
        step();
        step();
        reset_in = 1'b1;

        chk("rst_op_ready", int'(bus_if.op_ready), 1);
        chk("rst_busy", int'(bus_if.busy), 0);
        chk("rst_starts", int'({bus_if.mult_start, bus_if.div_start}), 0);
        chk("rst_writes", int'({bus_if.hi_write, bus_if.lo_write, bus_if.done}), 0);
        chk("rst_exc", int'({bus_if.div_zero_exc, bus_if.timeout_err}), 0);
        chk("rst_mux", int'({bus_if.mux_high, bus_if.mux_low}), 0);
        chk("rst_cycle_count", int'(bus_if.cycle_count), 0);

        for (int i = 0; i < 8; i++) begin
            run_vec(i, vecs[i]);
        end

        // Back-to-back MULTs with op_valid and mult_done held high: accepts every 4 cycles.
        n_done = 0; n_mstart = 0; n_ready = 0;
        bus_if.op_valid  = 1'b1;
        bus_if.mult_done = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (bus_if.done) n_done++;
            if (bus_if.mult_start) n_mstart++;
            if (bus_if.op_ready) n_ready++;
            if (c == 3) chk("b2b_done_c3", int'(bus_if.done), 1);
            if (c == 4) chk("b2b_ready_c4", int'(bus_if.op_ready), 1);
            if (c == 5) chk("b2b_mstart_c5", int'(bus_if.mult_start), 1);
            if (c == 8) clear_inputs();
        end
        chk("b2b_done_n", n_done, 2);
        chk("b2b_mstart_n", n_mstart, 2);
        chk("b2b_ready_n", n_ready, 2);
        chk("b2b_cycle_count", int'(bus_if.cycle_count), 1);
        step();
        step();

        // Reset pulse in the middle of WAIT aborts the op.
        bus_if.op_valid = 1'b1;
        step();
        bus_if.op_valid = 1'b0;
        step();
        step();
        chk("mid_in_wait_busy", int'(bus_if.busy), 1);
        reset_in = 1'b0;
        step();
        reset_in = 1'b1;
        chk("mid_rst_op_ready", int'(bus_if.op_ready), 1);
        chk("mid_rst_busy", int'(bus_if.busy), 0);
        chk("mid_rst_writes", int'({bus_if.hi_write, bus_if.lo_write, bus_if.done}), 0);
        chk("mid_rst_exc", int'({bus_if.div_zero_exc, bus_if.timeout_err}), 0);
        chk("mid_rst_cycle_count", int'(bus_if.cycle_count), 0);
        bus_if.mult_done = 1'b1;
        n_done = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (bus_if.hi_write || bus_if.done) n_done++;
        end
        chk("mid_rst_late_done_no_write", n_done, 0);
        clear_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
